rca_serial_32bit: RTL

Sequential digit-serial ripple-carry adder: the adding counterpart of the team's 32-bit ripple-carry subtractor. It computes a + b + cin over WIDTH/DIGIT clock cycles, DIGIT bits per cycle, with a single ripple carry register. It sits in the Arithmetic_Logic group as the area-lean alternative to the combinational adders. It has a start/done handshake so a bench or controller can drive it.

---
 rtl/rca_pkg.sv | 27 ++
 rtl/rca_digit.sv | 35 +++
 rtl/rca_serial_32bit.sv | 118 +++++++++++
 3 files changed

// File: rtl/rca_pkg.sv
// Shared constants, FSM state type and full-adder helper for the digit-serial adder.
// Latency: none (package only).
// Backpressure: none (package only).
package rca_pkg;

    localparam int RCA_WIDTH = 32;
    localparam int RCA_DIGIT = 4;
    localparam int RCA_N     = RCA_WIDTH / RCA_DIGIT;
    localparam int RCA_CNT_W = $clog2(RCA_N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } rca_state_t;

    // A single-digit configuration (N=1) still needs a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One full-adder cell: returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/rca_digit.sv
// Combinational W-bit ripple adder built from full-adder cells; also exposes carry into its MSB.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module rca_digit
    import rca_pkg::*;
#(
    parameter int W = RCA_DIGIT
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         cmsb
);

    logic       c_run;
    logic [1:0] fa;

    // Ripple the carry through W full-adder cells, remembering the carry entering the top cell.
    always_comb begin
        c_run = cin;
        cmsb  = cin;
        sum   = '0;
        fa    = '0;
        for (int i = 0; i < W; i++) begin
            cmsb   = c_run;
            fa     = full_add(a[i], b[i], c_run);
            sum[i] = fa[0];
            c_run  = fa[1];
        end
        cout = c_run;
    end

endmodule

// File: rtl/rca_serial_32bit.sv
// Digit-serial ripple-carry adder: a + b + cin, DIGIT bits per cycle; RCA_OVERFLOW_EN adds a signed overflow output.
// Latency: start accepted at edge E, done pulses for the cycle after edge E+N (N = WIDTH/DIGIT).
// Backpressure: start is taken only in IDLE/DONE; a start during RUN is dropped, not queued.
module rca_serial_32bit
    import rca_pkg::*;
#(
    parameter int WIDTH = RCA_WIDTH,
    parameter int DIGIT = RCA_DIGIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef RCA_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    rca_state_t            state;
    logic [WIDTH-1:0]      a_sh;
    logic [WIDTH-1:0]      b_sh;
    logic [WIDTH-1:0]      sum_sh;
    logic                  c_reg;
    logic [CW-1:0]         cnt;

    logic [DIGIT-1:0]       d_sum;
    logic                   d_cout;
    logic                   d_cmsb;
    logic [WIDTH+DIGIT-1:0] sum_cat;
    logic [WIDTH-1:0]       sum_nxt;

    rca_digit #(.W(DIGIT)) u_digit (
        .a    (a_sh[DIGIT-1:0]),
        .b    (b_sh[DIGIT-1:0]),
        .cin  (c_reg),
        .sum  (d_sum),
        .cout (d_cout),
        .cmsb (d_cmsb)
    );

    // New digit enters at the top; after N shifts digit 0 has reached the LSB.
    assign sum_cat = {d_sum, sum_sh};
    assign sum_nxt = sum_cat[WIDTH+DIGIT-1:DIGIT];

    // FSM, operand/sum shift registers, carry, counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            c_reg  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            carry  <= 1'b0;
`ifdef RCA_OVERFLOW_EN
            overflow <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        c_reg <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    sum_sh <= sum_nxt;
                    c_reg  <= d_cout;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= sum_nxt;
                        carry <= d_cout;
`ifdef RCA_OVERFLOW_EN
                        overflow <= d_cmsb ^ d_cout;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifndef RCA_OVERFLOW_EN
    // The MSB carry only feeds the optional overflow flag.
    logic unused_cmsb;
    assign unused_cmsb = d_cmsb;
`endif

endmodule
